multicycle_mips_core: RTL

// - Parametrised multi-cycle MIPS-subset core. It is the successor to the single-cycle CPU.
// - Fetch, decode, execute, memory and writeback run as separate FSM states.
// - One unified memory port with a ready handshake, so wait-state memories are supported.
// - Internal 32x32 register file; r0 is hardwired to zero.
// - Top-level testbenches and the memory model connect directly to this core.

---
 rtl/multicycle_mips_core.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_mips_core.sv
`default_nettype none
// multicycle_mips_core: multi-cycle MIPS subset with a unified ready-handshake memory port. Rev 1.0
// Define MCPU_PERF_CNT_EN to add the cycle_cnt / instret_cnt outputs.
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] HALT_WORD = 32'h0FC0_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] dbg_pc
`ifdef MCPU_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, target_q, target_d;
  logic [31:0]         ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]         alu_q, alu_d, mdr_q, mdr_d;
  logic                illegal_q, illegal_d;
  logic [31:0]         rf_q [32];
  logic [31:0]         rf_d [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_sext, w_opnd, w_alu, w_pc32, w_wb_val;
  logic        w_rtype_ok, w_supported, w_req_rd, w_req_wr;

  assign w_op     = ir_q[31:26];
  assign w_rs     = ir_q[25:21];
  assign w_rt     = ir_q[20:16];
  assign w_rd     = ir_q[15:11];
  assign w_funct  = ir_q[5:0];
  assign w_sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign w_pc32   = 32'(pc_q);
  assign w_opnd   = (w_op == OP_RTYPE) ? b_q : w_sext;
  assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wb_val = (w_op == OP_LW) ? mdr_q : alu_q;

  assign w_rtype_ok  = (w_op == OP_RTYPE) &&
                       ((w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                        (w_funct == FN_OR)  || (w_funct == FN_SLT));
  assign w_supported = w_rtype_ok || (w_op == OP_LW) || (w_op == OP_SW) ||
                       (w_op == OP_BEQ) || (w_op == OP_ADDI) || (w_op == OP_J);

  always_comb begin
    w_alu = a_q + w_opnd;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_SUB:  w_alu = a_q - b_q;
        FN_AND:  w_alu = a_q & b_q;
        FN_OR:   w_alu = a_q | b_q;
        FN_SLT:  w_alu = {31'b0, ($signed(a_q) < $signed(b_q))};
        default: w_alu = a_q + b_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    target_d  = target_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    rf_d      = rf_q;
    w_req_rd  = 1'b0;
    w_req_wr  = 1'b0;
    mem_addr  = pc_q;
    case (state_q)
      S_FETCH: begin
        w_req_rd = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rf_q[w_rs];
        b_d      = rf_q[w_rt];
        target_d = ADDR_W'(w_pc32 + (w_sext << 2));
        if (ir_q == HALT_WORD) begin
          state_d = S_HALT;
        end else if (!w_supported) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = w_alu;
        case (w_op)
          OP_BEQ: begin
            if (a_q == b_q) pc_d = target_q;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = ADDR_W'({w_pc32[31:28], ir_q[25:0], 2'b00});
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // Data address is forced word aligned; low address bits are never driven.
        mem_addr = ADDR_W'({alu_q[31:2], 2'b00});
        w_req_rd = (w_op == OP_LW);
        w_req_wr = (w_op != OP_LW);
        if (mem_ready) begin
          if (w_op == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        if (w_dest != 5'd0) rf_d[w_dest] = w_wb_val;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      target_q  <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      target_q  <= target_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      rf_q      <= rf_d;
    end
  end

  // Requests are gated by reset so they fall the instant reset is asserted.
  assign mem_rd    = w_req_rd & reset;
  assign mem_wr    = w_req_wr & reset;
  assign mem_wdata = b_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign dbg_pc    = pc_q;

`ifdef MCPU_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  logic        w_retire;

  always_comb begin
    case (state_q)
      S_EXEC:  w_retire = (w_op == OP_BEQ) || (w_op == OP_J);
      S_MEM:   w_retire = mem_ready && (w_op == OP_SW);
      S_WB:    w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
    cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    instret_cnt_d = w_retire ? instret_cnt_q + 32'd1 : instret_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
